// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// The master drives operands and out_ready. The slave (the ALU) drives in_ready and the result.
interface alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic [3:0]       opcode;
    logic [2:0]       SR_Cont;
    logic [SHW-1:0]   SR_Bit;
    logic             S;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic [3:0]       Flags;

    modport master (
        output in_valid, In1, In2, opcode, SR_Cont, SR_Bit, S, out_ready,
        input  in_ready, out_valid, Out, Flags
    );

    modport slave (
        input  in_valid, In1, In2, opcode, SR_Cont, SR_Bit, S, out_ready,
        output in_ready, out_valid, Out, Flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with {N,Z,C,V} flags, CMP, an iterative shift-add multiplier and valid/ready handshakes.
// Optional macro ALU_SEQ_ASR_EN makes SR_Cont=100 an arithmetic shift right.
//
// state | meaning
// IDLE  | waiting for an operand bundle
// BUSY  | multiplier iterating, one partial-product bit per cycle
// HOLD  | result presented, out_valid=1
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flags;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_s;

    logic [31:0]      w_amt;
    logic [31:0]      w_rot;
    logic [WIDTH-1:0] w_in3;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic             w_v_add;
    logic             w_v_sub;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_flags_nxt;
    logic             w_flag_en;
    logic             w_out_en;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_nxt;

    // Shifter on operand B; amounts at or past WIDTH only arise for non-power-of-two widths.
    always_comb begin
        w_amt = 32'(bus.SR_Bit);
        w_rot = w_amt % 32'(WIDTH);
        case (bus.SR_Cont)
            3'b001:  w_in3 = (w_amt >= 32'(WIDTH)) ? '0 : (bus.In2 >> w_amt);
            3'b010:  w_in3 = (w_amt >= 32'(WIDTH)) ? '0 : (bus.In2 << w_amt);
            3'b011:  w_in3 = (bus.In2 >> w_rot) | (bus.In2 << (32'(WIDTH) - w_rot));
`ifdef ALU_SEQ_ASR_EN
            3'b100:  w_in3 = $signed(bus.In2) >>> w_amt;
`endif
            default: w_in3 = bus.In2;
        endcase
    end

    always_comb begin
        w_sum       = {1'b0, bus.In1} + {1'b0, w_in3};
        w_dif       = {1'b0, bus.In1} - {1'b0, w_in3};
        w_v_add     = (bus.In1[MSB] == w_in3[MSB]) && (w_sum[MSB] != bus.In1[MSB]);
        w_v_sub     = (bus.In1[MSB] != w_in3[MSB]) && (w_dif[MSB] != bus.In1[MSB]);
        w_res       = '0;
        w_out_en    = 1'b1;
        w_flag_en   = 1'b0;
        w_flags_nxt = r_flags;
        case (bus.opcode)
            OP_ADD: begin
                w_res       = w_sum[MSB:0];
                w_flags_nxt = {w_sum[MSB], w_sum[MSB:0] == '0, w_sum[WIDTH], w_v_add};
                w_flag_en   = bus.S;
            end
            OP_SUB: begin
                w_res       = w_dif[MSB:0];
                w_flags_nxt = {w_dif[MSB], w_dif[MSB:0] == '0, ~w_dif[WIDTH], w_v_sub};
                w_flag_en   = bus.S;
            end
            OP_CMP: begin
                w_out_en    = 1'b0;
                w_flags_nxt = {w_dif[MSB], w_dif[MSB:0] == '0, ~w_dif[WIDTH], w_v_sub};
                w_flag_en   = 1'b1;
            end
            OP_OR, OP_AND, OP_XOR: begin
                if (bus.opcode == OP_OR)
                    w_res = bus.In1 | w_in3;
                else if (bus.opcode == OP_AND)
                    w_res = bus.In1 & w_in3;
                else
                    w_res = bus.In1 ^ w_in3;
                w_flags_nxt = {w_res[MSB], w_res == '0, r_flags[1:0]};
                w_flag_en   = bus.S;
            end
            default: ;
        endcase
    end

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_s         <= 1'b0;
        end else if (w_accept) begin
            if (bus.opcode == OP_MUL) begin
                r_state     <= S_BUSY;
                r_out_valid <= 1'b0;
                r_mcand     <= bus.In1;
                r_mplier    <= w_in3;
                r_acc       <= '0;
                r_cnt       <= CW'(WIDTH);
                r_s         <= bus.S;
            end else begin
                r_state     <= S_HOLD;
                r_out_valid <= 1'b1;
                if (w_out_en)
                    r_out <= w_res;
                if (w_flag_en)
                    r_flags <= w_flags_nxt;
            end
        end else begin
            case (r_state)
                S_BUSY: begin
                    // WIDTH iterations, then one more edge to publish the product.
                    if (r_cnt == '0) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_out       <= r_acc;
                        if (r_s)
                            r_flags <= {r_acc[MSB], r_acc == '0, r_flags[1:0]};
                    end else begin
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Out       = r_out;
    assign bus.Flags     = r_flags;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table of single-cycle ops plus MUL, reset-abort and backpressure sequences.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_seq_if #(.WIDTH(32), .SHW(5)) bus ();

    alu_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [2:0]  sc;
        logic [4:0]  sb;
        logic        s;
        logic [31:0] eo;
        logic [3:0]  ef;
    } vec_t;

    vec_t vt[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [2:0] sc, input logic [4:0] sb, input logic s);
        bus.In1     = a;
        bus.In2     = b;
        bus.opcode  = op;
        bus.SR_Cont = sc;
        bus.SR_Bit  = sb;
        bus.S       = s;
    endtask

    logic [31:0] asr_exp;
    int          cyc;
    logic        busy_ok;
    logic        seen;

    initial begin
`ifdef ALU_SEQ_ASR_EN
        asr_exp = 32'hC0000000;
`else
        asr_exp = 32'h80000001;
`endif
        vt[0]  = '{32'hFFFFFFFF, 32'h1,        4'd0,  3'd0, 5'd0,  1'b0, 32'h0,        4'b0000};
        vt[1]  = '{32'hFFFFFFFF, 32'h1,        4'd0,  3'd0, 5'd0,  1'b1, 32'h0,        4'b0110};
        vt[2]  = '{32'h5,        32'h7,        4'd6,  3'd0, 5'd0,  1'b0, 32'h0,        4'b1000};
        vt[3]  = '{32'h80000000, 32'h1,        4'd6,  3'd0, 5'd0,  1'b0, 32'h0,        4'b0011};
        vt[4]  = '{32'h0,        32'h80000001, 4'd3,  3'd3, 5'd1,  1'b1, 32'hC0000000, 4'b1011};
        vt[5]  = '{32'h0,        32'h80000001, 4'd3,  3'd1, 5'd1,  1'b1, 32'h40000000, 4'b0011};
        vt[6]  = '{32'h0,        32'h80000001, 4'd3,  3'd4, 5'd1,  1'b0, asr_exp,      4'b0011};
        vt[7]  = '{32'h3,        32'h5,        4'd1,  3'd0, 5'd0,  1'b1, 32'hFFFFFFFE, 4'b1000};
        vt[8]  = '{32'hF0F0,     32'h0FF0,     4'd4,  3'd0, 5'd0,  1'b1, 32'h000000F0, 4'b0000};
        vt[9]  = '{32'hAAAA,     32'hAAAA,     4'd5,  3'd0, 5'd0,  1'b1, 32'h0,        4'b0100};
        vt[10] = '{32'h7FFFFFFF, 32'h1,        4'd0,  3'd0, 5'd0,  1'b1, 32'h80000000, 4'b1001};
        vt[11] = '{32'h5,        32'h3,        4'hF,  3'd0, 5'd0,  1'b1, 32'h0,        4'b1001};
        vt[12] = '{32'h0,        32'h1,        4'd0,  3'd2, 5'd4,  1'b0, 32'h10,       4'b1001};
        vt[13] = '{32'h0,        32'h12345678, 4'd0,  3'd3, 5'd0,  1'b0, 32'h12345678, 4'b1001};
        vt[14] = '{32'h1,        32'h1,        4'd6,  3'd0, 5'd0,  1'b0, 32'h12345678, 4'b0110};
        vt[15] = '{32'h0,        32'h80000000, 4'd0,  3'd1, 5'd31, 1'b1, 32'h1,        4'b0000};
        vt[16] = '{32'h5,        32'h5,        4'd1,  3'd0, 5'd0,  1'b1, 32'h0,        4'b0110};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'h0, 32'h0, 4'd0, 3'd0, 5'd0, 1'b0);
        rst = 1'b1;
        step();
        step();
        chk("rst_out", bus.Out, 32'h0);
        chk("rst_flags", 32'(bus.Flags), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].a, vt[i].b, vt[i].op, vt[i].sc, vt[i].sb, vt[i].s);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("v%0d_out", i), bus.Out, vt[i].eo);
            chk($sformatf("v%0d_flags", i), 32'(bus.Flags), 32'(vt[i].ef));
            step();
            chk($sformatf("v%0d_drop", i), 32'(bus.out_valid), 32'h0);
        end

        // MUL latency and BUSY stall; flags before are 0110, so C must survive.
        drive(32'h12345, 32'h100, 4'd2, 3'd0, 5'd0, 1'b1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        drive(32'hDEAD, 32'hBEEF, 4'd0, 3'd0, 5'd0, 1'b1);
        cyc     = 0;
        busy_ok = 1'b1;
        while (cyc < 40 && !bus.out_valid) begin
            if (bus.in_ready) busy_ok = 1'b0;
            step();
            cyc++;
        end
        chk("mul_latency", 32'(cyc), 32'd33);
        chk("mul_busy_in_ready", 32'(busy_ok), 32'h1);
        chk("mul_out", bus.Out, 32'h01234500);
        chk("mul_flags", 32'(bus.Flags), 32'b0010);
        step();
        chk("mul_drop", 32'(bus.out_valid), 32'h0);

        // Reset during MUL aborts it.
        drive(32'h12345, 32'h100, 4'd2, 3'd0, 5'd0, 1'b1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        chk("mulrst_no_valid", 32'(seen), 32'h0);
        chk("mulrst_flags", 32'(bus.Flags), 32'h0);
        chk("mulrst_out", bus.Out, 32'h0);
        chk("mulrst_in_ready", 32'(bus.in_ready), 32'h1);

        // Backpressure then simultaneous transfer and accept.
        bus.out_ready = 1'b0;
        drive(32'hFFFFFFFF, 32'h2, 4'd0, 3'd0, 5'd0, 1'b1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        drive(32'h0, 32'h0, 4'd0, 3'd0, 5'd0, 1'b1);
        busy_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!bus.out_valid || bus.Out !== 32'h1 || bus.Flags !== 4'b0010 || bus.in_ready)
                busy_ok = 1'b0;
            step();
        end
        chk("bp_stable", 32'(busy_ok), 32'h1);
        chk("bp_out", bus.Out, 32'h1);
        drive(32'h1, 32'h1, 4'd0, 3'd0, 5'd0, 1'b1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        chk("b2b_valid", 32'(bus.out_valid), 32'h1);
        chk("b2b_out", bus.Out, 32'h2);
        chk("b2b_flags", 32'(bus.Flags), 32'b0000);
        step();
        chk("b2b_drop", 32'(bus.out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Adds a registered {N,Z,C,V} flag register, a CMP opcode, a multi-cycle iterative multiplier, and valid/ready handshakes on both operand and result sides.
- Sits between the register-file read stage and write-back. Downstream stalls are absorbed by holding the result.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 4).
- SHW, $clog2(WIDTH), width of the shift/rotate amount.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept the operand bundle.
- In1  in  WIDTH  operand A.
- In2  in  WIDTH  operand B, before the shifter.
- opcode  in  4  0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 CMP; others reserved.
- SR_Cont  in  3  shifter select applied to In2: 001 LSR, 010 LSL, 011 ROR, others pass-through.
- SR_Bit  in  SHW  shift/rotate amount.
- S  in  1  update flags on completion.
- out_valid  out  1  Out is valid.
- out_ready  in  1  consumer accepts Out.
- Out  out  WIDTH  registered result.
- Flags  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset values: Out=0, Flags=0, out_valid=0, state IDLE, multiplier registers 0. Reset mid-MUL aborts the operation; no result is produced.
- Handshake:
  - Operand transfer occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - Result transfer occurs when out_valid && out_ready.
  - Out and Flags are stable while out_valid && !out_ready.
- Operand capture: In3 = shifted In2 is computed combinationally and captured with In1, opcode and S at acceptance. Later input changes have no effect.
- States:
  - IDLE: waiting for an operand.
  - BUSY: MUL iterating.
  - HOLD: out_valid=1.
- Transitions:
  - IDLE→HOLD on a non-MUL accept.
  - IDLE→BUSY on a MUL accept.
  - BUSY→HOLD after WIDTH iterations.
  - HOLD→IDLE on result transfer without a new accept.
  - HOLD→HOLD or HOLD→BUSY on a simultaneous transfer plus accept (back-to-back operation).
- Latency:
  - Single-cycle ops: out_valid rises on the edge after acceptance (1 cycle).
  - MUL: out_valid rises WIDTH+1 edges after acceptance.
  - Sustained throughput is one single-cycle op per clock when out_ready=1.
- Shifts:
  - LSR and LSL with SR_Bit ≥ WIDTH cannot occur unless WIDTH is not a power of two; in that case the result is 0.
  - ROR uses SR_Bit mod WIDTH.
  - SR_Bit=0 passes In2 unchanged.
- Arithmetic: all results are truncated to WIDTH bits.
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: A−B; C = 1 when there is no borrow (A ≥ B unsigned); V = signed overflow.
  - MUL: shift-add, one partial-product bit per cycle; Out = low WIDTH bits of A×B.
- Flag rules:
  - N = Out[WIDTH-1]; Z = (Out==0).
  - MUL, OR, AND and XOR update N and Z only; C and V are preserved.
  - Flags load on the same edge out_valid rises, only if S=1 or opcode=CMP.
- CMP: Out keeps its previous value; out_valid still pulses through HOLD so issue ordering is preserved.
- Reserved opcodes: Out=0, flags unchanged regardless of S, completes in 1 cycle.

Optional Feature:
- Macro ALU_SEQ_ASR_EN.
- Defined: SR_Cont=100 selects arithmetic shift right. Vacated bits are filled with In2[WIDTH-1]. An amount ≥ WIDTH yields all sign bits.
- Undefined: SR_Cont=100 is pass-through, like other unlisted codes.

Test Plan:
- ADD, WIDTH=32: In1=0xFFFFFFFF, In2=1, S=1, out_ready=1 → one cycle later Out=0, Flags=0110 (Z,C). With S=0 the same op leaves Flags=0000.
- CMP: In1=5, In2=7 → Out unchanged, Flags=1000 (N=1, C=0 borrow, V=0). Then CMP In1=0x80000000, In2=1 → Flags=0011 (C=1, V=1).
- MUL: In1=0x12345, In2=0x100, SR_Cont=000 → out_valid exactly 33 cycles after acceptance with Out=0x01234500. in_ready=0 throughout BUSY; reset asserted at cycle 10 → out_valid stays 0, Flags=0.
- Shifter: In2=0x80000001, SR_Bit=1: SR_Cont=011 ROR, opcode OR, In1=0 → Out=0xC0000000. SR_Cont=001 → Out=0x40000000. SR_Cont=100 → Out=0xC0000000 with ALU_SEQ_ASR_EN defined, 0x80000001 without.
- Backpressure: out_ready=0 for 5 cycles after an ADD completes → Out and Flags stable, in_ready=0. Raise out_ready with in_valid=1 → result transfer and new accept on the same edge; next result valid on the following edge.
- Reserved opcode 4'hF, S=1 → Out=0, Flags unchanged, out_valid for one handshake.
